varicode_encoder: RTL and testbench
===================================

VARICODE_ENCODER -- requirements
Module: varicode_encoder

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 6_400_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BR, default 100, output bit rate in bit/s.
REQ-003 SHALL have parameter IDLE_FILL, default 1; 1 = emit 0-bits while idle, 0 = emit no bits while idle.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port char_in  input  8  ASCII character to encode.
REQ-007 SHALL have port char_valid  input  1  char_in is valid.
REQ-008 SHALL have port char_ready  output  1  encoder can accept a character.
REQ-009 SHALL have port bit_out  output  1  serial varicode bit.
REQ-010 SHALL have port bit_valid  output  1  one-cycle strobe; bit_out is valid.
REQ-011 SHALL have port busy  output  1  high while a character or its gap is in flight.
REQ-012 SHALL have port char_err  output  1  one-cycle pulse; an unencodable character was accepted.

Function
REQ-013 SHALL compute BIT_DIV = SYS_CLK_FREQ/BR, with BIT_DIV >= 4 (default 64_000).
REQ-014 SHALL have a free-running 32-bit tick counter: 0..BIT_DIV-1, wraps to 0, with a one-cycle tick at count BIT_DIV-1; the counter is never restarted by a handshake.
REQ-015 SHALL map char_in 0x00-0x7F to the standard PSK31 varicode as {length 1..10, code}, sent MSB-first. Examples: 0x20 -> "1", 0x65 'e' -> "11", 0x74 't' -> "101", 0x61 'a' -> "1011", 0x45 'E' -> "1110111", 0x00 -> "1010101011".
REQ-016 SHALL register the looked-up code and length; the table is not on the bit_out path.
REQ-017 SHALL implement the FSM states IDLE, LOAD, SEND, GAP and ERR.
REQ-018 IDLE: char_ready=1; on char_valid&&char_ready, capture char_in and go to LOAD; char_ready drops in the following cycle.
REQ-019 LOAD (one cycle): if char_in[7]=1, go to ERR; else latch code/length into the shift register and bit counter, then go to SEND.
REQ-020 ERR (one cycle): char_err=1, emit no bits, return to IDLE.
REQ-021 SEND: on each tick, drive bit_out = current MSB and pulse bit_valid; shift and decrement the counter; after the last code bit, go to GAP.
REQ-022 GAP: on each of the next two ticks, emit bit_out=0 with bit_valid; after the second, return to IDLE.
REQ-023 IDLE with IDLE_FILL=1: each tick emits bit_out=0 with bit_valid=1. With IDLE_FILL=0: bit_valid stays 0.
REQ-024 Handshake vs tick: if an accept occurs in the same cycle as an IDLE tick, that tick still emits its fill bit; the first code bit goes out on the next tick.
REQ-025 The first code bit SHALL be emitted on the first tick at least 2 cycles after the accept.
REQ-026 bit_out and bit_valid SHALL be registered; bit_valid is high for exactly one cycle per tick when emitting.
REQ-027 busy SHALL be high in LOAD, SEND and GAP, and low in IDLE and ERR.
REQ-028 Between characters the stream SHALL contain at least two consecutive 0s (GAP); no code contains "00", so a receiver can delimit characters by "00" followed by 1.
REQ-029 char_valid deasserted without acceptance SHALL have no effect; char_in is don't-care while char_valid=0.

Reset
REQ-030 While rst=0, all state SHALL be forced asynchronously: FSM=IDLE, tick counter=0, shift register=0, bit counter=0, char_ready=0, bit_out=0, bit_valid=0, busy=0, char_err=0.
REQ-031 char_ready SHALL rise on the first clk edge after rst deasserts.
REQ-032 Reset mid-character SHALL abort the character with no further code or gap bits.

Verification
REQ-033 Scenario: BR chosen so BIT_DIV=8, IDLE_FILL=1; send 'e' (0x65) -> bits 1,1,0,0 on successive ticks, then continuous 0s; busy high from LOAD through the 2nd gap bit.
REQ-034 Scenario: send 't' then 'E' back-to-back with char_valid held -> 1,0,1,0,0 then 1,1,1,0,1,1,1,0,0, with no extra fill bit between them; char_ready high exactly one cycle between the characters.
REQ-035 Scenario: send 0x00 -> 10 bits 1,0,1,0,1,0,1,0,1,1 followed by 0,0; bit counter handles length 10 without wrap.
REQ-036 Scenario: send 0x80 -> char_err pulses one cycle, no bits other than idle fill, and char_ready returns within 3 cycles.
REQ-037 Scenario: assert rst after the 3rd bit of 'E' -> outputs go to reset values immediately; after release, only idle 0s are emitted until a new accept.
REQ-038 Scenario: IDLE_FILL=0, send space (0x20) -> exactly three bit_valid strobes (1,0,0) and none while idle.

Source files
------------

// File: rtl/varicode_encoder.sv
// PSK31 varicode serializer: accepts ASCII characters and emits their varicode
// MSB-first at the bit rate, followed by a two-zero inter-character gap.
module varicode_encoder #(
    parameter int unsigned SYS_CLK_FREQ = 6_400_000,
    parameter int unsigned BR           = 100,
    parameter bit          IDLE_FILL    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       char_err
);

    localparam int unsigned BIT_DIV   = SYS_CLK_FREQ / BR;
    localparam logic [31:0] TICK_LAST = 32'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] tick_cnt;
    logic        tick;
    logic [7:0]  char_reg;
    logic [9:0]  shift_reg;
    logic [3:0]  bit_cnt;
    logic        accept;
    logic        emit;
    logic        emit_bit;
    logic [13:0] lut;

    // Returns {length, code left-aligned in 10 bits}. Every varicode starts
    // with a 1, so the length follows from the highest set bit.
    function automatic logic [13:0] varicode(input logic [6:0] c);
        logic [9:0] code;
        logic [9:0] aligned;
        logic [3:0] len;
        code = 10'b0;
        case (c)
            7'h00: code = 10'b1010101011;
            7'h01: code = 10'b1011011011;
            7'h02: code = 10'b1011101101;
            7'h03: code = 10'b1101110111;
            7'h04: code = 10'b1011101011;
            7'h05: code = 10'b1101011111;
            7'h06: code = 10'b1011101111;
            7'h07: code = 10'b1011111101;
            7'h08: code = 10'b1011111111;
            7'h09: code = 10'b11101111;
            7'h0A: code = 10'b11101;
            7'h0B: code = 10'b1101101111;
            7'h0C: code = 10'b1011011101;
            7'h0D: code = 10'b11111;
            7'h0E: code = 10'b1101110101;
            7'h0F: code = 10'b1110101011;
            7'h10: code = 10'b1011110111;
            7'h11: code = 10'b1011110101;
            7'h12: code = 10'b1110101101;
            7'h13: code = 10'b1110101111;
            7'h14: code = 10'b1101011011;
            7'h15: code = 10'b1101101011;
            7'h16: code = 10'b1101101101;
            7'h17: code = 10'b1101010111;
            7'h18: code = 10'b1101111011;
            7'h19: code = 10'b1101111101;
            7'h1A: code = 10'b1110110111;
            7'h1B: code = 10'b1101010101;
            7'h1C: code = 10'b1101011101;
            7'h1D: code = 10'b1110111011;
            7'h1E: code = 10'b1011111011;
            7'h1F: code = 10'b1101111111;
            7'h20: code = 10'b1;
            7'h21: code = 10'b111111111;
            7'h22: code = 10'b101011111;
            7'h23: code = 10'b111110101;
            7'h24: code = 10'b111011011;
            7'h25: code = 10'b1011010101;
            7'h26: code = 10'b1010111011;
            7'h27: code = 10'b101111111;
            7'h28: code = 10'b11111011;
            7'h29: code = 10'b11110111;
            7'h2A: code = 10'b101101111;
            7'h2B: code = 10'b111011111;
            7'h2C: code = 10'b1110101;
            7'h2D: code = 10'b110101;
            7'h2E: code = 10'b1010111;
            7'h2F: code = 10'b110101111;
            7'h30: code = 10'b10110111;
            7'h31: code = 10'b10111101;
            7'h32: code = 10'b11101101;
            7'h33: code = 10'b11111111;
            7'h34: code = 10'b101110111;
            7'h35: code = 10'b101011011;
            7'h36: code = 10'b101101011;
            7'h37: code = 10'b110101101;
            7'h38: code = 10'b110101011;
            7'h39: code = 10'b110110111;
            7'h3A: code = 10'b11110101;
            7'h3B: code = 10'b110111101;
            7'h3C: code = 10'b111101101;
            7'h3D: code = 10'b1010101;
            7'h3E: code = 10'b111010111;
            7'h3F: code = 10'b1010101111;
            7'h40: code = 10'b1010111101;
            7'h41: code = 10'b1111101;
            7'h42: code = 10'b11101011;
            7'h43: code = 10'b10101101;
            7'h44: code = 10'b10110101;
            7'h45: code = 10'b1110111;
            7'h46: code = 10'b11011011;
            7'h47: code = 10'b11111101;
            7'h48: code = 10'b101010101;
            7'h49: code = 10'b1111111;
            7'h4A: code = 10'b111111101;
            7'h4B: code = 10'b101111101;
            7'h4C: code = 10'b11010111;
            7'h4D: code = 10'b10111011;
            7'h4E: code = 10'b11011101;
            7'h4F: code = 10'b10101011;
            7'h50: code = 10'b11010101;
            7'h51: code = 10'b111011101;
            7'h52: code = 10'b10101111;
            7'h53: code = 10'b1101111;
            7'h54: code = 10'b1101101;
            7'h55: code = 10'b101010111;
            7'h56: code = 10'b110110101;
            7'h57: code = 10'b101011101;
            7'h58: code = 10'b101110101;
            7'h59: code = 10'b101111011;
            7'h5A: code = 10'b1010101101;
            7'h5B: code = 10'b111110111;
            7'h5C: code = 10'b111101111;
            7'h5D: code = 10'b111111011;
            7'h5E: code = 10'b1010111111;
            7'h5F: code = 10'b101101101;
            7'h60: code = 10'b1011011111;
            7'h61: code = 10'b1011;
            7'h62: code = 10'b1011111;
            7'h63: code = 10'b101111;
            7'h64: code = 10'b101101;
            7'h65: code = 10'b11;
            7'h66: code = 10'b111101;
            7'h67: code = 10'b1011011;
            7'h68: code = 10'b101011;
            7'h69: code = 10'b1101;
            7'h6A: code = 10'b111101011;
            7'h6B: code = 10'b10111111;
            7'h6C: code = 10'b11011;
            7'h6D: code = 10'b111011;
            7'h6E: code = 10'b1111;
            7'h6F: code = 10'b111;
            7'h70: code = 10'b111111;
            7'h71: code = 10'b110111111;
            7'h72: code = 10'b10101;
            7'h73: code = 10'b10111;
            7'h74: code = 10'b101;
            7'h75: code = 10'b110111;
            7'h76: code = 10'b1111011;
            7'h77: code = 10'b1101011;
            7'h78: code = 10'b11011111;
            7'h79: code = 10'b1011101;
            7'h7A: code = 10'b111010101;
            7'h7B: code = 10'b1010110111;
            7'h7C: code = 10'b110111011;
            7'h7D: code = 10'b1010110101;
            7'h7E: code = 10'b1011010111;
            7'h7F: code = 10'b1110110101;
            default: code = 10'b1;
        endcase
        len = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (code[i]) len = 4'(i + 1);
        end
        aligned = code << (4'd10 - len);
        return {len, aligned};
    endfunction

    assign tick   = (tick_cnt == TICK_LAST);
    assign accept = char_valid && char_ready;
    assign lut    = varicode(char_reg[6:0]);

    // Bit-rate timebase runs freely so accepts never shift the bit grid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= 32'd0;
        end else if (tick) begin
            tick_cnt <= 32'd0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_bit   = 1'b0;
        case (state)
            IDLE: begin
                emit = tick & IDLE_FILL;
                if (accept) state_next = LOAD;
            end
            LOAD: state_next = char_reg[7] ? ERR : SEND;
            SEND: begin
                if (tick) begin
                    emit     = 1'b1;
                    emit_bit = shift_reg[9];
                    if (bit_cnt == 4'd1) state_next = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    emit = 1'b1;
                    if (bit_cnt == 4'd1) state_next = IDLE;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_reg   <= 8'd0;
            shift_reg  <= 10'd0;
            bit_cnt    <= 4'd0;
            char_ready <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            char_err   <= 1'b0;
        end else begin
            bit_valid  <= emit;
            bit_out    <= emit_bit;
            char_ready <= (state_next == IDLE);
            busy       <= (state_next inside {LOAD, SEND, GAP});
            char_err   <= (state_next == ERR);
            if (state == IDLE && accept) char_reg <= char_in;
            case (state)
                LOAD: begin
                    if (!char_reg[7]) begin
                        shift_reg <= lut[9:0];
                        bit_cnt   <= lut[13:10];
                    end
                end
                SEND: begin
                    if (tick) begin
                        shift_reg <= {shift_reg[8:0], 1'b0};
                        // bit counter is reused to count the two gap bits
                        bit_cnt   <= (bit_cnt == 4'd1) ? 4'd2 : bit_cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (tick) bit_cnt <= bit_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_varicode_encoder.sv
// Directed bench for varicode_encoder at BIT_DIV=8, with one instance using
// idle fill and one without.
module tb_varicode_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in, char_in0;
    logic       char_valid, char_valid0;
    logic       char_ready, bit_out, bit_valid, busy, char_err;
    logic       char_ready0, bit_out0, bit_valid0, busy0, char_err0;

    int n_checks = 0;
    int n_fail   = 0;
    logic q1[$];
    logic q0[$];
    int   err_cnt  = 0;
    int   busy_cnt = 0;
    int   base, bbase, ebase, k;

    always #5 clk = ~clk;

    varicode_encoder #(.SYS_CLK_FREQ(800), .BR(100), .IDLE_FILL(1'b1)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .busy(busy), .char_err(char_err)
    );

    varicode_encoder #(.SYS_CLK_FREQ(800), .BR(100), .IDLE_FILL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .char_in(char_in0), .char_valid(char_valid0),
        .char_ready(char_ready0), .bit_out(bit_out0), .bit_valid(bit_valid0),
        .busy(busy0), .char_err(char_err0)
    );

    always @(negedge clk) begin
        if (bit_valid) q1.push_back(bit_out);
        if (bit_valid0) q0.push_back(bit_out0);
        if (char_err) err_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic q[$], input int b,
                             input logic [15:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s[%0d]", tag, i), 32'(q[b + i]), 32'(exp[n - 1 - i]));
        end
    endtask

    task automatic wait_q(input string tag, input int n, input int budget);
        int c = 0;
        while (q1.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check_eq({tag, "_bits_arrived"}, 32'(q1.size() >= n), 32'd1);
    endtask

    function automatic int ones_from(input int b);
        int n = 0;
        for (int i = b; i < q1.size(); i++) begin
            if (q1[i]) n++;
        end
        return n;
    endfunction

    task automatic send_one(input logic [7:0] c, output int b);
        int c2 = 0;
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        while (!char_ready && c2 < 100) begin
            @(negedge clk);
            c2++;
        end
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        @(negedge clk);
        #1;
        b = q1.size();
    endtask

    initial begin
        rst = 1'b0;
        char_in = 8'd0;  char_valid = 1'b0;
        char_in0 = 8'd0; char_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(char_ready), 32'd0);
        check_eq("rst_bit_valid", 32'(bit_valid), 32'd0);
        check_eq("rst_bit_out", 32'(bit_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(char_err), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", 32'(char_ready), 32'd1);
        check_eq("ready0_after_rst", 32'(char_ready0), 32'd1);

        // space on the no-fill instance
        @(negedge clk);
        check_eq("fill0_none_before", 32'(q0.size()), 32'd0);
        char_in0 = 8'h20;
        char_valid0 = 1'b1;
        @(posedge clk);
        #1;
        char_valid0 = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check_eq("sp_fill0_count", 32'(q0.size()), 32'd3);
        check_seq("sp_fill0", q0, 0, 16'b100, 3);
        check_eq("idle_fill_count", 32'(q1.size() >= 6), 32'd1);
        check_eq("idle_fill_zero", 32'(ones_from(0)), 32'd0);

        // 'e' accepted in the same cycle as a tick
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bit_valid && k < 20);
        check_eq("align_strobe", 32'(bit_valid), 32'd1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        char_in = 8'h65;
        char_valid = 1'b1;
        base  = q1.size();
        bbase = busy_cnt;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        @(negedge clk);
        check_eq("e_busy_load", 32'(busy), 32'd1);
        check_eq("e_ready_load", 32'(char_ready), 32'd0);
        check_eq("e_fill_on_accept_tick", 32'(bit_valid), 32'd1);
        wait_q("e", base + 6, 80);
        check_seq("e", q1, base, 16'b011000, 6);
        check_eq("e_busy_cycles", 32'(busy_cnt - bbase), 32'd32);

        // 't' then 'E' back to back with valid held
        @(negedge clk);
        char_in = 8'h74;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        base = q1.size();
        k = 0;
        while (!char_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("tE_ready_between", 32'(char_ready), 32'd1);
        char_in = 8'h45;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        @(negedge clk);
        check_eq("tE_ready_one_cycle", 32'(char_ready), 32'd0);
        wait_q("tE", base + 15, 200);
        check_seq("tE", q1, base, 16'b101001110111000, 15);

        // NUL: longest code
        send_one(8'h00, base);
        wait_q("nul", base + 13, 200);
        check_seq("nul", q1, base, 16'b1010101011000, 13);

        // 0x80: unencodable
        ebase = err_cnt;
        @(negedge clk);
        char_in = 8'h80;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        base = q1.size();
        @(negedge clk);
        check_eq("err_load_busy", 32'(busy), 32'd1);
        check_eq("err_load_pulse", 32'(char_err), 32'd0);
        @(negedge clk);
        check_eq("err_pulse", 32'(char_err), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("err_pulse_end", 32'(char_err), 32'd0);
        check_eq("err_ready_back", 32'(char_ready), 32'd1);
        repeat (20) @(negedge clk);
        #1;
        check_eq("err_pulse_count", 32'(err_cnt - ebase), 32'd1);
        check_eq("err_no_code_bits", 32'(ones_from(base)), 32'd0);

        // reset after the 3rd bit of 'E'
        send_one(8'h45, base);
        wait_q("E_rst", base + 3, 100);
        check_eq("E_rst_pre_out", 32'(bit_out), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("E_rst_bit_valid", 32'(bit_valid), 32'd0);
        check_eq("E_rst_bit_out", 32'(bit_out), 32'd0);
        check_eq("E_rst_busy", 32'(busy), 32'd0);
        check_eq("E_rst_ready", 32'(char_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("E_rst_ready_rise", 32'(char_ready), 32'd1);
        base = q1.size();
        repeat (48) @(negedge clk);
        #1;
        check_eq("E_rst_fill_count", 32'(q1.size() >= base + 5), 32'd1);
        check_eq("E_rst_only_zeros", 32'(ones_from(base)), 32'd0);
        check_eq("fill0_silent", 32'(q0.size()), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
